sig_gate_sequencer: RTL and testbench

Issue/collect side of the gate activation path. Accepts a stream of 8-bit operand pairs with a valid/ready handshake and drives them onto the operand inputs of the fixed-latency add/sub + sigmoid activation unit. It captures each activation result exactly LATENCY cycles later into a result FIFO. Results are presented in order on a valid/ready output with the vector-end marker preserved. Issue is credit-based, so the FIFO never overflows.

---
 rtl/sig_gate_sequencer.sv | 140 ++++++++++++++
 tb/tb_sig_gate_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_gate_sequencer.sv
// Issue/collect sequencer for the fixed-latency add/sub + sigmoid activation unit.
// Operands are issued against credits; results are captured LATENCY cycles later into an in-order FIFO.
module sig_gate_sequencer #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic [7:0]       act_a,
    output logic [7:0]       act_b,
    input  logic [7:0]       act_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] vec_done
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FCNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W  = $clog2(DEPTH + LATENCY + 2);

    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);
    localparam logic [CNT_W-1:0]  VEC_ONE  = CNT_W'(1);
    localparam logic [SUM_W-1:0]  CREDITS  = SUM_W'(DEPTH);

    // Number of operand pairs still travelling through the activation unit.
    function automatic logic [SUM_W-1:0] popcount(input logic [LATENCY:0] v);
        logic [SUM_W-1:0] n;
        n = '0;
        for (int i = 0; i <= LATENCY; i++) begin
            n = n + SUM_W'(v[i]);
        end
        return n;
    endfunction

    logic [LATENCY:0]  tag_r;
    logic [LATENCY:0]  last_r;
    logic [7:0]        act_a_r;
    logic [7:0]        act_b_r;
    logic [7:0]        mem_data_r [DEPTH];
    logic              mem_last_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [FCNT_W-1:0] count_r;
    logic [FCNT_W-1:0] count_nxt_s;
    logic [CNT_W-1:0]  vec_done_r;

    logic [SUM_W-1:0]  inflight_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;

    // Credits only depend on registered state, so ready never follows in_valid or out_ready combinationally.
    assign inflight_s = popcount(tag_r);
    assign in_ready_s = (SUM_W'(count_r) + inflight_s) < CREDITS;
    assign accept_s   = in_valid && in_ready_s;
    assign push_s     = tag_r[LATENCY];
    assign pop_s      = (count_r != '0) && out_ready;

    assign in_ready  = in_ready_s;
    assign act_a     = act_a_r;
    assign act_b     = act_b_r;
    assign out_valid = (count_r != '0);
    assign out_data  = mem_data_r[rd_ptr_r];
    assign out_last  = mem_last_r[rd_ptr_r];
    assign busy      = (inflight_s != '0) || (count_r != '0);
    assign vec_done  = vec_done_r;

    // Operand registers and the tag/last pipe that tracks when each result appears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_r   <= '0;
            last_r  <= '0;
            act_a_r <= 8'h00;
            act_b_r <= 8'h00;
        end else begin
            tag_r  <= {tag_r[LATENCY-1:0], accept_s};
            last_r <= {last_r[LATENCY-1:0], in_last};
            if (accept_s) begin
                act_a_r <= in_a;
                act_b_r <= in_b;
            end
        end
    end

    // Next occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + FCNT_ONE;
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - FCNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Result FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_r[i] <= 8'h00;
                mem_last_r[i] <= 1'b0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_data_r[wr_ptr_r] <= act_result;
                mem_last_r[wr_ptr_r] <= last_r[LATENCY];
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Retired-vector counter, bumped when the last result of a vector leaves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vec_done_r <= '0;
        end else if (pop_s && mem_last_r[rd_ptr_r]) begin
            vec_done_r <= vec_done_r + VEC_ONE;
        end
    end

endmodule

// File: tb/tb_sig_gate_sequencer.sv
// Bench for sig_gate_sequencer: queue-based reference model, directed scenarios plus random traffic.
module tb_sig_gate_sequencer;

    localparam int LAT = 2;
    localparam int DEP = 8;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_last;
    logic [7:0]  act_a;
    logic [7:0]  act_b;
    logic [7:0]  act_result;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic [15:0] vec_done;

    sig_gate_sequencer #(.LATENCY(LAT), .DEPTH(DEP), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .act_a(act_a), .act_b(act_b), .act_result(act_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .vec_done(vec_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in activation unit: XOR of the held operands, LAT cycles later.
    logic [7:0] act_d1;
    logic [7:0] act_d2;
    initial begin
        act_d1 = 8'h00;
        act_d2 = 8'h00;
    end
    always @(posedge clk) begin
        act_d1 <= act_a ^ act_b;
        act_d2 <= act_d1;
    end
    assign act_result = act_d2;

    typedef struct { logic [7:0] d; logic l; int land; } pend_t;
    typedef struct { logic [7:0] d; logic l; } ent_t;

    pend_t pq[$];
    ent_t  fq[$];
    int    cyc;
    int    m_vec;
    logic [7:0] m_act_a;
    logic [7:0] m_act_b;
    logic  m_acc;
    logic  m_pop;

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_rdy();
        return (fq.size() + pq.size()) < DEP;
    endfunction

    task automatic model_reset();
        pq.delete();
        fq.delete();
        m_vec   = 0;
        m_act_a = 8'h00;
        m_act_b = 8'h00;
    endtask

    task automatic model_edge();
        ent_t  e;
        pend_t p;
        cyc++;
        if (m_pop) begin
            e = fq.pop_front();
            if (e.l) m_vec = (m_vec + 1) % 65536;
        end
        while (pq.size() > 0 && pq[0].land == cyc) begin
            p = pq.pop_front();
            e.d = p.d;
            e.l = p.l;
            fq.push_back(e);
        end
        if (m_acc) begin
            p.d = in_a ^ in_b;
            p.l = in_last;
            p.land = cyc + LAT + 1;
            pq.push_back(p);
            m_act_a = in_a;
            m_act_b = in_b;
        end
    endtask

    task automatic check_model();
        chk("in_ready", 32'(in_ready), 32'(m_rdy()));
        chk("out_valid", 32'(out_valid), 32'(fq.size() != 0));
        if (fq.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(fq[0].d));
            chk("out_last", 32'(out_last), 32'(fq[0].l));
        end
        chk("busy", 32'(busy), 32'((fq.size() + pq.size()) != 0));
        chk("vec_done", 32'(vec_done), 32'(m_vec));
        chk("act_a", 32'(act_a), 32'(m_act_a));
        chk("act_b", 32'(act_b), 32'(m_act_b));
    endtask

    // Called at a negedge: drive, advance one clock, check at the next negedge.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic l, input logic r);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_last   = l;
        out_ready = r;
        m_acc = v && m_rdy();
        m_pop = (fq.size() != 0) && r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n_acc;
        int idx;
        int vec_before;
        logic [7:0] held_d;
        logic held_l;
        logic [7:0] lens [3];

        checks = 0;
        errors = 0;
        cyc = 0;
        model_reset();
        reset_n = 1'b0;
        in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vec_done", 32'(vec_done), 32'd0);
        chk("rst_act_a", 32'(act_a), 32'd0);
        check_model();

        // Single pair: result visible after the third following edge.
        step(1'b1, 8'h12, 8'h34, 1'b1, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("single_not_early", 32'(out_valid), 32'd0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'h26);
        chk("single_last", 32'(out_last), 32'd1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("single_vec_done", 32'(vec_done), 32'd1);
        chk("single_busy", 32'(busy), 32'd0);

        // 20 back-to-back pairs with the consumer always ready.
        for (int i = 0; i < 20; i++) begin
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
            step(1'b1, 8'(i), 8'hF0, 1'(i == 19), 1'b1);
            if (i >= 3) chk("b2b_no_gap", 32'(out_valid), 32'd1);
        end
        drain(5);

        // Fill with consumer stalled: exactly DEPTH accepts.
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'(8'h40 + i), 8'h0F, 1'(i == 7), 1'b0);
            if (m_acc) n_acc++;
        end
        chk("fill_accepts", 32'(n_acc), 32'd8);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_out_data", 32'(out_data), 32'h4F);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("fill_ready_after_pop", 32'(in_ready), 32'd1);
        drain(10);

        // Full boundary with toggling out_ready; vectors of length 3, 5, 1.
        lens[0] = 8'd3; lens[1] = 8'd5; lens[2] = 8'd1;
        vec_before = int'(vec_done);
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h80 + idx), 8'h55, 1'(idx == 2 || idx == 7 || idx == 8), 1'b0);
            if (m_acc) idx++;
        end
        for (int i = 0; i < 40; i++) begin
            if (idx < 9) begin
                step(1'b1, 8'(8'h80 + idx), 8'h55, 1'(idx == 2 || idx == 7 || idx == 8), 1'(i % 2));
                if (m_acc) idx++;
            end else begin
                step(1'b0, 8'h00, 8'h00, 1'b0, 1'(i % 2));
            end
        end
        chk("boundary_all_accepted", 32'(idx), 32'(lens[0] + lens[1] + lens[2]));
        chk("boundary_vec_done", 32'(vec_done), 32'(vec_before + 3));
        chk("boundary_idle", 32'(busy), 32'd0);

        // Stall hold: head must not move while out_ready is low.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 8'h3C, 1'(i == 2), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        held_d = out_data;
        held_l = out_last;
        chk("stall_head", 32'(held_d), 32'hFC);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            chk("stall_data", 32'(out_data), 32'(held_d));
            chk("stall_last", 32'(out_last), 32'(held_l));
        end
        drain(6);

        // Asynchronous reset with 2 in flight and 4 queued.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hA0 + i), 8'h11, 1'(i == 5), 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("pre_rst_queued", 32'(fq.size()), 32'd4);
        chk("pre_rst_inflight", 32'(pq.size()), 32'd2);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_vec_done", 32'(vec_done), 32'd0);
        chk("arst_act_a", 32'(act_a), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        check_model();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            chk("post_rst_no_stale", 32'(out_valid), 32'd0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'(($urandom % 4) != 0), 8'($urandom), 8'($urandom),
                 1'(($urandom % 4) == 0), 1'(($urandom % 3) != 0));
        end
        drain(15);
        chk("final_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
